// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS memory stage: access-size codes, FSM states
// and the byte-lane enable lookup.
package mem_stage_pkg;

   localparam logic [1:0] MEM_SIZE_BYTE    = 2'd0;
   localparam logic [1:0] MEM_SIZE_HALF    = 2'd1;
   localparam logic [1:0] MEM_SIZE_WORD    = 2'd2;
   localparam logic [1:0] MEM_SIZE_ILLEGAL = 2'd3;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   // Little-endian lane enables for an access of the given size at a byte offset.
   function automatic logic [3:0] mem_byte_enable(input logic [1:0] size,
                                                  input logic [1:0] offset);
      logic [3:0] be;
      case (size)
         MEM_SIZE_BYTE: be = 4'b0001 << offset;
         MEM_SIZE_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
         MEM_SIZE_WORD: be = 4'b1111;
         default:       be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute-side, data-memory and write-back/forwarding signals of the memory stage.
// The slave modport is the memory stage itself; master is its environment.
interface mem_stage_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
);
   logic                      inValid;
   logic                      inReady;
   logic [DATA_WIDTH-1:0]     inAluOutput;
   logic [DATA_WIDTH-1:0]     inStoreData;
   logic [REG_ADDR_WIDTH-1:0] inRegisterWriteAddress;
   logic                      inShouldWriteRegister;
   logic                      inMemRead;
   logic                      inMemWrite;
   logic [1:0]                inMemSize;
   logic                      inLoadUnsigned;

   logic                      dmemRequest;
   logic                      dmemWrite;
   logic [DATA_WIDTH-1:0]     dmemAddress;
   logic [3:0]                dmemByteEnable;
   logic [DATA_WIDTH-1:0]     dmemWriteData;
   logic                      dmemReady;
   logic [DATA_WIDTH-1:0]     dmemReadData;

   logic                      outValid;
   logic [REG_ADDR_WIDTH-1:0] outRegisterWriteAddress;
   logic                      outShouldWriteRegister;
   logic [DATA_WIDTH-1:0]     outWriteData;
   logic                      misalignedException;
   logic                      forwardValid;
   logic [REG_ADDR_WIDTH-1:0] forwardRegisterAddress;
   logic [DATA_WIDTH-1:0]     forwardData;

   modport slave (
      input  inValid, inAluOutput, inStoreData, inRegisterWriteAddress,
             inShouldWriteRegister, inMemRead, inMemWrite, inMemSize, inLoadUnsigned,
             dmemReady, dmemReadData,
      output inReady, dmemRequest, dmemWrite, dmemAddress, dmemByteEnable, dmemWriteData,
             outValid, outRegisterWriteAddress, outShouldWriteRegister, outWriteData,
             misalignedException, forwardValid, forwardRegisterAddress, forwardData
   );

   modport master (
      output inValid, inAluOutput, inStoreData, inRegisterWriteAddress,
             inShouldWriteRegister, inMemRead, inMemWrite, inMemSize, inLoadUnsigned,
             dmemReady, dmemReadData,
      input  inReady, dmemRequest, dmemWrite, dmemAddress, dmemByteEnable, dmemWriteData,
             outValid, outRegisterWriteAddress, outShouldWriteRegister, outWriteData,
             misalignedException, forwardValid, forwardRegisterAddress, forwardData
   );
endinterface

// File: rtl/mem_stage_load_store_aligner.sv
// Combinational alignment check, lane-enable/store-replication for the request
// side, and lane extraction/extension of returned load data.
module load_store_aligner
   import mem_stage_pkg::*;
(
   input  logic [31:0] req_address,
   input  logic [1:0]  req_size,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [31:0] req_store_data,
   output logic        req_fault,
   output logic [31:0] req_word_address,
   output logic [3:0]  req_byte_enable,
   output logic [31:0] req_write_data,
   input  logic [1:0]  rsp_offset,
   input  logic [1:0]  rsp_size,
   input  logic        rsp_unsigned,
   input  logic [31:0] rsp_read_data,
   output logic [31:0] rsp_load_data
);

   logic        misaligned_s;
   logic [15:0] lane_s;

   // Size-dependent alignment rule; size code 3 is never a legal access.
   always_comb begin
      misaligned_s = 1'b0;
      case (req_size)
         MEM_SIZE_BYTE: misaligned_s = 1'b0;
         MEM_SIZE_HALF: misaligned_s = req_address[0];
         MEM_SIZE_WORD: misaligned_s = (req_address[1:0] != 2'b00);
         default:       misaligned_s = 1'b1;
      endcase
   end

   assign req_fault        = (req_read | req_write) & (misaligned_s | (req_read & req_write));
   assign req_word_address = {req_address[31:2], 2'b00};
   assign req_byte_enable  = mem_byte_enable(req_size, req_address[1:0]);

   // Replicate store data across every lane so the enabled lane always carries it.
   always_comb begin
      req_write_data = req_store_data;
      case (req_size)
         MEM_SIZE_BYTE: req_write_data = {4{req_store_data[7:0]}};
         MEM_SIZE_HALF: req_write_data = {2{req_store_data[15:0]}};
         default:       req_write_data = req_store_data;
      endcase
   end

   // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
   always_comb begin
      lane_s        = 16'(rsp_read_data >> {rsp_offset, 3'b000});
      rsp_load_data = rsp_read_data;
      case (rsp_size)
         MEM_SIZE_BYTE: rsp_load_data = {{24{~rsp_unsigned & lane_s[7]}}, lane_s[7:0]};
         MEM_SIZE_HALF: rsp_load_data = {{16{~rsp_unsigned & lane_s[15]}}, lane_s[15:0]};
         default:       rsp_load_data = rsp_read_data;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: registers execute results, runs loads/stores over a
// request/ready data-memory port and stalls execute while an access is open.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
)(
   input logic           clk,
   input logic           rst_n,
   mem_stage_if.slave    bus
);

   state_t                    state_r;
   logic                      in_ready_r;
   logic                      dmem_request_r;
   logic                      dmem_write_r;
   logic [DATA_WIDTH-1:0]     dmem_address_r;
   logic [3:0]                dmem_byte_enable_r;
   logic [DATA_WIDTH-1:0]     dmem_write_data_r;
   logic                      out_valid_r;
   logic [REG_ADDR_WIDTH-1:0] out_rd_r;
   logic                      out_we_r;
   logic [DATA_WIDTH-1:0]     out_data_r;
   logic                      misaligned_r;
   logic                      forward_valid_r;

   logic [DATA_WIDTH-1:0]     pend_address_r;
   logic [1:0]                pend_size_r;
   logic                      pend_unsigned_r;
   logic [REG_ADDR_WIDTH-1:0] pend_rd_r;
   logic                      pend_we_r;

   logic                      mem_access_s;
   logic                      rd_we_s;
   logic                      fault_s;
   logic [DATA_WIDTH-1:0]     word_address_s;
   logic [3:0]                byte_enable_s;
   logic [DATA_WIDTH-1:0]     write_data_s;
   logic [DATA_WIDTH-1:0]     load_data_s;

   assign mem_access_s = bus.inMemRead | bus.inMemWrite;
   assign rd_we_s      = bus.inShouldWriteRegister &
                         (bus.inRegisterWriteAddress != {REG_ADDR_WIDTH{1'b0}});

   load_store_aligner u_aligner (
      .req_address      (bus.inAluOutput),
      .req_size         (bus.inMemSize),
      .req_read         (bus.inMemRead),
      .req_write        (bus.inMemWrite),
      .req_store_data   (bus.inStoreData),
      .req_fault        (fault_s),
      .req_word_address (word_address_s),
      .req_byte_enable  (byte_enable_s),
      .req_write_data   (write_data_s),
      .rsp_offset       (pend_address_r[1:0]),
      .rsp_size         (pend_size_r),
      .rsp_unsigned     (pend_unsigned_r),
      .rsp_read_data    (bus.dmemReadData),
      .rsp_load_data    (load_data_s)
   );

   // Stage FSM with all outputs registered; reset abandons any open access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r            <= IDLE;
         in_ready_r         <= 1'b1;
         dmem_request_r     <= 1'b0;
         dmem_write_r       <= 1'b0;
         dmem_address_r     <= {DATA_WIDTH{1'b0}};
         dmem_byte_enable_r <= 4'b0000;
         dmem_write_data_r  <= {DATA_WIDTH{1'b0}};
         out_valid_r        <= 1'b0;
         out_rd_r           <= {REG_ADDR_WIDTH{1'b0}};
         out_we_r           <= 1'b0;
         out_data_r         <= {DATA_WIDTH{1'b0}};
         misaligned_r       <= 1'b0;
         forward_valid_r    <= 1'b0;
         pend_address_r     <= {DATA_WIDTH{1'b0}};
         pend_size_r        <= 2'b00;
         pend_unsigned_r    <= 1'b0;
         pend_rd_r          <= {REG_ADDR_WIDTH{1'b0}};
         pend_we_r          <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.inValid && !mem_access_s) begin
                  out_valid_r     <= 1'b1;
                  out_rd_r        <= bus.inRegisterWriteAddress;
                  out_we_r        <= rd_we_s;
                  out_data_r      <= bus.inAluOutput;
                  forward_valid_r <= rd_we_s;
                  misaligned_r    <= 1'b0;
               end else if (bus.inValid && fault_s) begin
                  // Rejected access retires immediately without touching memory.
                  out_valid_r     <= 1'b1;
                  out_rd_r        <= bus.inRegisterWriteAddress;
                  out_we_r        <= 1'b0;
                  out_data_r      <= bus.inAluOutput;
                  forward_valid_r <= 1'b0;
                  misaligned_r    <= 1'b1;
               end else if (bus.inValid) begin
                  state_r            <= WAIT;
                  in_ready_r         <= 1'b0;
                  dmem_request_r     <= 1'b1;
                  dmem_write_r       <= bus.inMemWrite;
                  dmem_address_r     <= word_address_s;
                  dmem_byte_enable_r <= byte_enable_s;
                  dmem_write_data_r  <= write_data_s;
                  pend_address_r     <= bus.inAluOutput;
                  pend_size_r        <= bus.inMemSize;
                  pend_unsigned_r    <= bus.inLoadUnsigned;
                  pend_rd_r          <= bus.inRegisterWriteAddress;
                  pend_we_r          <= rd_we_s & bus.inMemRead;
                  out_valid_r        <= 1'b0;
                  forward_valid_r    <= 1'b0;
                  misaligned_r       <= 1'b0;
               end else begin
                  out_valid_r     <= 1'b0;
                  forward_valid_r <= 1'b0;
                  misaligned_r    <= 1'b0;
               end
            end
            WAIT: begin
               misaligned_r <= 1'b0;
               if (bus.dmemReady) begin
                  state_r         <= IDLE;
                  in_ready_r      <= 1'b1;
                  dmem_request_r  <= 1'b0;
                  out_valid_r     <= 1'b1;
                  out_rd_r        <= pend_rd_r;
                  out_we_r        <= pend_we_r;
                  forward_valid_r <= pend_we_r;
                  out_data_r      <= dmem_write_r ? pend_address_r : load_data_s;
               end else begin
                  out_valid_r     <= 1'b0;
                  forward_valid_r <= 1'b0;
               end
            end
            default: begin
               state_r         <= IDLE;
               in_ready_r      <= 1'b1;
               dmem_request_r  <= 1'b0;
               out_valid_r     <= 1'b0;
               forward_valid_r <= 1'b0;
               misaligned_r    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.inReady                 = in_ready_r;
   assign bus.dmemRequest             = dmem_request_r;
   assign bus.dmemWrite               = dmem_write_r;
   assign bus.dmemAddress             = dmem_address_r;
   assign bus.dmemByteEnable          = dmem_byte_enable_r;
   assign bus.dmemWriteData           = dmem_write_data_r;
   assign bus.outValid                = out_valid_r;
   assign bus.outRegisterWriteAddress = out_rd_r;
   assign bus.outShouldWriteRegister  = out_we_r;
   assign bus.outWriteData            = out_data_r;
   assign bus.misalignedException     = misaligned_r;
   assign bus.forwardValid            = forward_valid_r;
   assign bus.forwardRegisterAddress  = out_rd_r;
   assign bus.forwardData             = out_data_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases followed by random
// instructions checked against an arithmetic reference model.
module tb_mem_stage;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   mem_stage_if bus ();

   mem_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit legal_access(input bit rd, input bit wr, input int size, input int off);
      if (rd && wr) return 1'b0;
      if (size == 3) return 1'b0;
      if (size == 1 && (off % 2) != 0) return 1'b0;
      if (size == 2 && off != 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [3:0] exp_be(input int size, input int off);
      int v;
      if (size == 0) v = 1 << off;
      else if (size == 1) v = 3 << off;
      else v = 15;
      return v[3:0];
   endfunction

   function automatic logic [31:0] exp_wdata(input int size, input logic [31:0] d);
      if (size == 0) return {24'd0, d[7:0]} * 32'h0101_0101;
      if (size == 1) return {16'd0, d[15:0]} * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] exp_load(input int size, input int off, input bit uns,
                                            input logic [31:0] word);
      longint v;
      longint span;
      int     bits;
      bits = (size == 0) ? 8 : (size == 1) ? 16 : 32;
      span = longint'(1) << bits;
      v    = longint'(word >> (8 * off)) % span;
      if (!uns && bits < 32 && v >= span / 2) v = v - span;
      return v[31:0];
   endfunction

   // Presents one instruction, services any memory request after 'waits'
   // not-ready cycles and checks the stage against the model.
   task automatic run_instr(input string tag, input bit mr, input bit mw, input int size,
                            input bit uns, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [4:0] rd, input bit sw, input int waits,
                            input logic [31:0] rdata);
      int  off;
      bit  acc;
      bit  legal;
      bit  we;
      off   = int'(addr[1:0]);
      acc   = mr || mw;
      legal = acc ? legal_access(mr, mw, size, off) : 1'b1;
      we    = sw && (rd != 5'd0) && legal && !mw;

      check({tag, " ready_idle"}, bus.inReady, 1'b1);
      bus.inValid                = 1'b1;
      bus.inAluOutput            = addr;
      bus.inStoreData            = sdata;
      bus.inRegisterWriteAddress = rd;
      bus.inShouldWriteRegister  = sw;
      bus.inMemRead              = mr;
      bus.inMemWrite             = mw;
      bus.inMemSize              = 2'(size);
      bus.inLoadUnsigned         = uns;
      @(posedge clk); #1;
      bus.inValid    = 1'b0;
      bus.inMemRead  = 1'b0;
      bus.inMemWrite = 1'b0;

      if (acc && legal) begin
         for (int w = 0; w <= waits; w++) begin
            bus.dmemReady    = (w == waits);
            bus.dmemReadData = (w == waits) ? rdata : $urandom;
            @(negedge clk);
            check({tag, " req"}, bus.dmemRequest, 1'b1);
            check({tag, " ready_low"}, bus.inReady, 1'b0);
            check({tag, " out_idle"}, bus.outValid, 1'b0);
            check({tag, " dwrite"}, bus.dmemWrite, mw);
            check({tag, " daddr"}, bus.dmemAddress, {addr[31:2], 2'b00});
            check({tag, " be"}, bus.dmemByteEnable, exp_be(size, off));
            if (mw) check({tag, " wdata"}, bus.dmemWriteData, exp_wdata(size, sdata));
            @(posedge clk); #1;
         end
         bus.dmemReady = 1'b0;
      end

      @(negedge clk);
      check({tag, " valid"}, bus.outValid, 1'b1);
      check({tag, " req_off"}, bus.dmemRequest, 1'b0);
      check({tag, " ready_back"}, bus.inReady, 1'b1);
      check({tag, " misaligned"}, bus.misalignedException, acc && !legal);
      check({tag, " we"}, bus.outShouldWriteRegister, we);
      check({tag, " fwd_valid"}, bus.forwardValid, we);
      if (we) begin
         check({tag, " rd"}, bus.outRegisterWriteAddress, rd);
         check({tag, " fwd_rd"}, bus.forwardRegisterAddress, rd);
      end
      if (!acc) check({tag, " alu_data"}, bus.outWriteData, addr);
      if (mr && legal) check({tag, " load_data"}, bus.outWriteData, exp_load(size, off, uns, rdata));
      check({tag, " fwd_data"}, bus.forwardData, bus.outWriteData);
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, " pulse_end"}, bus.outValid, 1'b0);
      check({tag, " exc_end"}, bus.misalignedException, 1'b0);
   endtask

   initial begin
      bus.inValid                = 1'b0;
      bus.inAluOutput            = 32'd0;
      bus.inStoreData            = 32'd0;
      bus.inRegisterWriteAddress = 5'd0;
      bus.inShouldWriteRegister  = 1'b0;
      bus.inMemRead              = 1'b0;
      bus.inMemWrite             = 1'b0;
      bus.inMemSize              = 2'd0;
      bus.inLoadUnsigned         = 1'b0;
      bus.dmemReady              = 1'b0;
      bus.dmemReadData           = 32'd0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #10;
      check("rst inReady", bus.inReady, 1'b1);
      check("rst req", bus.dmemRequest, 1'b0);
      check("rst be", bus.dmemByteEnable, 4'b0000);
      check("rst valid", bus.outValid, 1'b0);
      check("rst data", bus.outWriteData, 32'd0);
      check("rst fwd", bus.forwardValid, 1'b0);
      check("rst exc", bus.misalignedException, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_instr("alu",    1'b0, 1'b0, 2, 1'b0, 32'h0000_00AB, 32'd0, 5'd7, 1'b1, 0, 32'd0);
      run_instr("alu_r0", 1'b0, 1'b0, 2, 1'b0, 32'h1234_5678, 32'd0, 5'd0, 1'b1, 0, 32'd0);
      run_instr("lw",     1'b1, 1'b0, 2, 1'b0, 32'h0000_1000, 32'd0, 5'd9, 1'b1, 3, 32'hDEAD_BEEF);
      run_instr("lb",     1'b1, 1'b0, 0, 1'b0, 32'h0000_1003, 32'd0, 5'd3, 1'b1, 1, 32'h8012_3456);
      run_instr("lbu",    1'b1, 1'b0, 0, 1'b1, 32'h0000_1003, 32'd0, 5'd3, 1'b1, 0, 32'h8012_3456);
      run_instr("lh",     1'b1, 1'b0, 1, 1'b0, 32'h0000_1002, 32'd0, 5'd4, 1'b1, 2, 32'h8765_1234);
      run_instr("sh",     1'b0, 1'b1, 1, 1'b0, 32'h0000_2002, 32'h0000_1234, 5'd5, 1'b1, 1, 32'd0);
      run_instr("sb",     1'b0, 1'b1, 0, 1'b0, 32'h0000_2001, 32'h0000_00C5, 5'd0, 1'b0, 0, 32'd0);
      run_instr("lw_mis", 1'b1, 1'b0, 2, 1'b0, 32'h0000_1001, 32'd0, 5'd6, 1'b1, 0, 32'd0);
      run_instr("lh_mis", 1'b1, 1'b0, 1, 1'b0, 32'h0000_1003, 32'd0, 5'd6, 1'b1, 0, 32'd0);
      run_instr("sz3",    1'b1, 1'b0, 3, 1'b0, 32'h0000_1000, 32'd0, 5'd6, 1'b1, 0, 32'd0);
      run_instr("rdwr",   1'b1, 1'b1, 2, 1'b0, 32'h0000_1000, 32'd0, 5'd6, 1'b1, 0, 32'd0);

      // Reset in the middle of an outstanding load.
      bus.inValid                = 1'b1;
      bus.inAluOutput            = 32'h0000_3000;
      bus.inRegisterWriteAddress = 5'd8;
      bus.inShouldWriteRegister  = 1'b1;
      bus.inMemRead              = 1'b1;
      bus.inMemSize              = 2'd2;
      @(posedge clk); #1;
      bus.inValid   = 1'b0;
      bus.inMemRead = 1'b0;
      @(negedge clk);
      check("rstw req_before", bus.dmemRequest, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rstw req_drop", bus.dmemRequest, 1'b0);
      check("rstw ready", bus.inReady, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("rstw no_valid", bus.outValid, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rstw no_valid2", bus.outValid, 1'b0);
      check("rstw req_idle", bus.dmemRequest, 1'b0);
      run_instr("post_rst", 1'b0, 1'b0, 2, 1'b0, 32'h0000_0055, 32'd0, 5'd2, 1'b1, 0, 32'd0);

      for (int i = 0; i < 60; i++) begin
         int          kind;
         int          size;
         logic [31:0] addr;
         kind = $urandom_range(0, 4);
         size = $urandom_range(0, 3);
         addr = $urandom;
         if ($urandom_range(0, 2) != 0 && size == 2) addr[1:0] = 2'b00;
         if ($urandom_range(0, 2) != 0 && size == 1) addr[0] = 1'b0;
         run_instr("rand", kind == 1 || kind == 3 || kind == 4, kind == 2 || kind == 4,
                   size, 1'($urandom_range(0, 1)), addr, $urandom, 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
